// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, branch/return redirects and
// two-cycle vector loads (reset/interrupt) read through instruction memory.
module pc_sequencer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] pc_src_i,
    input  logic [1:0] inst_mem_src_i,
    input  logic       flush_i,
    input  logic       stall_i,
    input  logic [7:0] branch_target_i,
    input  logic [7:0] ret_data_i,
    input  logic [7:0] imem_data_i,
    output logic [7:0] pc_o,
    output logic [7:0] imem_addr_o,
    output logic       fetch_valid_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic       busy_o,
    output logic [7:0] int_ret_pc_o,
    output logic       int_save_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        VEC_REQ  = 2'd1,
        VEC_LOAD = 2'd2
    } state_e;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_MEM    = 2'b10;

    localparam logic [1:0] MEM_RESET  = 2'd1;
    localparam logic [1:0] MEM_INT    = 2'd2;
    localparam logic [1:0] MEM_RET    = 2'd3;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] vec_addr_q, vec_addr_d;
    logic [7:0] int_ret_pc_q, int_ret_pc_d;
    logic       int_save_q, int_save_d;
    logic       err_q, err_d;

    // NOTE: reset lands in VEC_REQ so every boot fetches the reset vector first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= VEC_REQ;
            pc_q         <= 8'h00;
            vec_addr_q   <= 8'h00;
            int_ret_pc_q <= 8'h00;
            int_save_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            vec_addr_q   <= vec_addr_d;
            int_ret_pc_q <= int_ret_pc_d;
            int_save_q   <= int_save_d;
            err_q        <= err_d;
        end
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        vec_addr_d   = vec_addr_q;
        int_ret_pc_d = int_ret_pc_q;
        int_save_d   = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            RUN: begin
                case (pc_src_i)
                    SRC_SEQ: begin
                        if (!stall_i) begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                    SRC_BRANCH: pc_d = branch_target_i;
                    SRC_MEM: begin
                        case (inst_mem_src_i)
                            MEM_RET:   pc_d = ret_data_i;
                            MEM_RESET: begin
                                vec_addr_d = 8'h00;
                                state_d    = VEC_REQ;
                            end
                            MEM_INT: begin
                                vec_addr_d   = 8'h01;
                                int_ret_pc_d = pc_q;
                                int_save_d   = 1'b1;
                                state_d      = VEC_REQ;
                            end
                            default:   err_d = 1'b1;
                        endcase
                    end
                    default: err_d = 1'b1;
                endcase
            end
            VEC_REQ:  state_d = VEC_LOAD;
            // Memory data returned here belongs to the address issued in VEC_REQ.
            VEC_LOAD: begin
                pc_d    = imem_data_i;
                state_d = RUN;
            end
            default: begin
                vec_addr_d = 8'h00;
                state_d    = VEC_REQ;
            end
        endcase
    end

    always_comb begin
        imem_addr_o   = vec_addr_q;
        fetch_valid_o = 1'b0;
        busy_o        = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (state_q == RUN) begin
            imem_addr_o   = pc_q;
            fetch_valid_o = !flush_i;
            busy_o        = 1'b0;
            flush_if_id_o = flush_i;
            flush_id_ex_o = flush_i;
        end
    end

    assign pc_o         = pc_q;
    assign int_ret_pc_o = int_ret_pc_q;
    assign int_save_o   = int_save_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a cycle-level reference model compared
// on every falling edge, plus directed scenarios pinned by literal expectations.
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] pc_src;
    logic [1:0] ims;
    logic       flush;
    logic       stall;
    logic [7:0] bt;
    logic [7:0] ret_data;
    logic [7:0] imem_data;
    logic [7:0] pc_o;
    logic [7:0] imem_addr_o;
    logic       fetch_valid_o;
    logic       flush_if_id_o;
    logic       flush_id_ex_o;
    logic       busy_o;
    logic [7:0] int_ret_pc_o;
    logic       int_save_o;
    logic       err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem [256];

    pc_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_src_i        (pc_src),
        .inst_mem_src_i  (ims),
        .flush_i         (flush),
        .stall_i         (stall),
        .branch_target_i (bt),
        .ret_data_i      (ret_data),
        .imem_data_i     (imem_data),
        .pc_o            (pc_o),
        .imem_addr_o     (imem_addr_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .busy_o          (busy_o),
        .int_ret_pc_o    (int_ret_pc_o),
        .int_save_o      (int_save_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data one cycle after the address.
    always @(posedge clk) imem_data <= mem[imem_addr_o];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    // Reference model: load_left counts remaining vector-load cycles (2 = address
    // cycle, 1 = data cycle, 0 = running).
    logic [7:0] m_pc, m_vec, m_ret;
    logic       m_save, m_err;
    int         load_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 8'h00; m_vec = 8'h00; m_ret = 8'h00;
            m_save = 1'b0; m_err = 1'b0; load_left = 2;
        end else begin
            m_save = 1'b0;
            m_err  = 1'b0;
            if (load_left == 2) begin
                load_left = 1;
            end else if (load_left == 1) begin
                m_pc = mem[m_vec];
                load_left = 0;
            end else if (pc_src == 2'b01) begin
                m_pc = bt;
            end else if (pc_src == 2'b00) begin
                if (!stall) m_pc = 8'((int'(m_pc) + 1) % 256);
            end else if (pc_src == 2'b10 && ims == 2'd3) begin
                m_pc = ret_data;
            end else if (pc_src == 2'b10 && ims == 2'd1) begin
                m_vec = 8'h00; load_left = 2;
            end else if (pc_src == 2'b10 && ims == 2'd2) begin
                m_vec = 8'h01; m_ret = m_pc; m_save = 1'b1; load_left = 2;
            end else begin
                m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("pc", pc_o, m_pc);
        check("busy", 8'(busy_o), 8'(load_left != 0));
        check("fetch_valid", 8'(fetch_valid_o), 8'(load_left == 0 && !flush));
        check("flush_if_id", 8'(flush_if_id_o), 8'(load_left != 0 || flush));
        check("flush_id_ex", 8'(flush_id_ex_o), 8'(load_left != 0 || flush));
        check("int_save", 8'(int_save_o), 8'(m_save));
        check("int_ret_pc", int_ret_pc_o, m_ret);
        check("err", 8'(err_o), 8'(m_err));
        if (load_left == 2)      check("imem_addr_vec", imem_addr_o, m_vec);
        else if (load_left == 0) check("imem_addr_run", imem_addr_o, m_pc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        pc_src = 2'b00; ims = 2'd0; flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[0] = 8'h20;
        mem[1] = 8'h80;
        bt = 8'h00; ret_data = 8'h00;
        idle();
        rst = 1'b1;

        // Boot: reset-vector load, then run from M[0x00].
        tick(); tick();
        check("rst_pc", pc_o, 8'h00);
        check("rst_addr", imem_addr_o, 8'h00);
        check("rst_busy", 8'(busy_o), 8'h01);
        check("rst_int_save", 8'(int_save_o), 8'h00);
        rst = 1'b0;
        tick();
        check("boot_load_fv", 8'(fetch_valid_o), 8'h00);
        check("boot_load_busy", 8'(busy_o), 8'h01);
        tick();
        check("boot_pc", pc_o, 8'h20);
        check("boot_fv", 8'(fetch_valid_o), 8'h01);

        // Sequential with wrap, then stall hold.
        pc_src = 2'b01; bt = 8'hFE; tick();
        check("jump_fe", pc_o, 8'hFE);
        pc_src = 2'b00;
        tick(); check("seq_ff", pc_o, 8'hFF);
        tick(); check("seq_00", pc_o, 8'h00);
        tick(); check("seq_01", pc_o, 8'h01);
        stall = 1'b1;
        tick(); check("stall_hold", pc_o, 8'h01);
        tick(); check("stall_hold2", pc_o, 8'h01);

        // Branch overrides stall; flushes are combinational in the request cycle.
        idle(); pc_src = 2'b01; bt = 8'h10; tick();
        stall = 1'b1; bt = 8'h40; flush = 1'b1;
        #1;
        check("br_flush_ifid", 8'(flush_if_id_o), 8'h01);
        check("br_flush_idex", 8'(flush_id_ex_o), 8'h01);
        check("br_fv_flushed", 8'(fetch_valid_o), 8'h00);
        tick(); check("br_pc", pc_o, 8'h40);

        // Flush alone does not change sequencing.
        idle(); flush = 1'b1; tick();
        check("flush_seq_pc", pc_o, 8'h41);

        // Interrupt vector load; a branch applied mid-load is dropped.
        idle(); pc_src = 2'b01; bt = 8'h33; tick();
        pc_src = 2'b10; ims = 2'd2; tick();
        check("int_ret_pc", int_ret_pc_o, 8'h33);
        check("int_save_pulse", 8'(int_save_o), 8'h01);
        check("int_addr", imem_addr_o, 8'h01);
        check("int_hold_pc", pc_o, 8'h33);
        idle(); pc_src = 2'b01; bt = 8'h55; stall = 1'b1; tick();
        check("int_save_done", 8'(int_save_o), 8'h00);
        tick(); idle();
        check("int_pc", pc_o, 8'h80);

        // Return over stall, then illegal redirects.
        pc_src = 2'b10; ims = 2'd3; ret_data = 8'h34; stall = 1'b1; tick();
        check("ret_pc", pc_o, 8'h34);
        pc_src = 2'b11; stall = 1'b0; tick();
        check("ill_pc", pc_o, 8'h34);
        check("ill_err", 8'(err_o), 8'h01);
        idle(); stall = 1'b1; tick();
        check("ill_err_off", 8'(err_o), 8'h00);
        pc_src = 2'b10; ims = 2'd0; tick();
        check("ill0_err", 8'(err_o), 8'h01);
        check("ill0_pc", pc_o, 8'h34);

        // Software reset-vector redirect.
        idle(); pc_src = 2'b10; ims = 2'd1; tick();
        idle(); tick(); tick();
        check("swrst_pc", pc_o, 8'h20);

        // Reset during the data cycle of an interrupt load.
        pc_src = 2'b10; ims = 2'd2; tick();
        idle(); tick();
        #1 rst = 1'b1;
        #1;
        check("midrst_pc", pc_o, 8'h00);
        check("midrst_save", 8'(int_save_o), 8'h00);
        check("midrst_ret", int_ret_pc_o, 8'h00);
        tick();
        rst = 1'b0;
        check("midrst_addr", imem_addr_o, 8'h00);
        tick();
        check("midrst_fv", 8'(fetch_valid_o), 8'h00);
        tick();
        check("midrst_boot_pc", pc_o, 8'h20);
        tick();
        check("post_boot_pc", pc_o, 8'h21);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL provide Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide PCSrc, input, 2 bits: redirect select from the branch unit; 00 = sequential, 01 = branch target, 10 = memory-sourced, 11 = illegal.
REQ-004 SHALL provide inst_mem_src, input, 2 bits: source when PCSrc=10; 1 = reset vector M[0x00], 2 = interrupt vector M[0x01], 3 = stack return value, 0 = illegal.
REQ-005 SHALL provide Flush, input, 1 bit: pipeline flush request from the branch unit.
REQ-006 SHALL provide Stall, input, 1 bit: hazard stall; holds the PC.
REQ-007 SHALL provide Branch_Target, input, 8 bits: jump, call or loop target address.
REQ-008 SHALL provide Ret_Data, input, 8 bits: popped return address for RET/RTI.
REQ-009 SHALL provide Imem_Data, input, 8 bits: instruction memory read data, valid one cycle after Imem_Addr.
REQ-010 SHALL provide PC, output, 8 bits: current program counter.
REQ-011 SHALL provide Imem_Addr, output, 8 bits: instruction memory address.
REQ-012 SHALL provide Fetch_Valid, output, 1 bit: the fetched word is a real instruction.
REQ-013 SHALL provide Flush_IF_ID and Flush_ID_EX, outputs, 1 bit each: pipeline register clears.
REQ-014 SHALL provide Busy, output, 1 bit: a vector load is in progress.
REQ-015 SHALL provide Int_Ret_PC, output, 8 bits, and Int_Save, output, 1 bit: the interrupt return address and its push strobe.
REQ-016 SHALL provide Err, output, 1 bit: one-cycle pulse on an illegal redirect.

Function
REQ-017 FSM states SHALL be RUN, VEC_REQ and VEC_LOAD.
REQ-018 In RUN, Imem_Addr SHALL equal PC and Fetch_Valid SHALL be the inverse of Flush.
REQ-019 In VEC_REQ, Imem_Addr SHALL equal the latched vector address Vec_Addr_q; Fetch_Valid SHALL be 0 and Busy SHALL be 1.
REQ-020 From VEC_REQ, the FSM SHALL move unconditionally to VEC_LOAD.
REQ-021 In VEC_LOAD, Fetch_Valid SHALL be 0 and Busy SHALL be 1; on the edge, PC <= Imem_Data and the FSM SHALL return to RUN.
REQ-022 In RUN with PCSrc=00 and Stall=0, PC SHALL become PC+1 modulo 256 (0xFF wraps to 0x00).
REQ-023 In RUN with PCSrc=00 and Stall=1, PC SHALL hold.
REQ-024 In RUN with PCSrc=01, PC SHALL become Branch_Target; this SHALL override Stall.
REQ-025 In RUN with PCSrc=10 and inst_mem_src=3, PC SHALL become Ret_Data in one cycle; this SHALL override Stall.
REQ-026 In RUN with PCSrc=10 and inst_mem_src=1 or 2, the block SHALL latch Vec_Addr_q = 0x00 or 0x01 respectively, enter VEC_REQ, and hold PC.
REQ-027 On accepting inst_mem_src=2, Int_Ret_PC SHALL capture the PC value, and Int_Save SHALL pulse high for exactly the VEC_REQ cycle.
REQ-028 In RUN with PCSrc=11, or with PCSrc=10 and inst_mem_src=0, PC SHALL hold and Err SHALL pulse high for 1 cycle.
REQ-029 Flush_IF_ID and Flush_ID_EX SHALL be asserted combinationally when Flush=1 in RUN, and throughout VEC_REQ and VEC_LOAD.
REQ-030 PCSrc, inst_mem_src, Flush and Stall SHALL be ignored while Busy=1; redirects arriving then SHALL be dropped, not queued.
REQ-031 Redirect latency SHALL be 1 cycle for PCSrc=01 and for inst_mem_src=3, and 2 cycles after acceptance for vector loads (PC valid in the 3rd cycle).

Reset
REQ-032 Reset assertion SHALL immediately force PC=0x00, state=VEC_REQ, Vec_Addr_q=0x00, Int_Ret_PC=0x00, Int_Save=0 and Err=0.
REQ-033 Reset asserted during VEC_REQ or VEC_LOAD SHALL abort the load and restart at REQ-032.
REQ-034 After Reset deasserts, the block SHALL perform the reset-vector load (VEC_REQ, then VEC_LOAD) before entering RUN; Busy=1 during both cycles.

Verification
REQ-035 Boot: M[0x00]=0x20, pulse Reset -> Imem_Addr=0x00 for 1 cycle, then PC=0x20 in RUN after 2 cycles; Fetch_Valid=0 until then.
REQ-036 Sequential and wrap: PC=0xFE, PCSrc=00 for 3 cycles -> PC sequence 0xFF, 0x00, 0x01; with Stall=1, PC holds.
REQ-037 Branch over stall: PC=0x10, Stall=1, PCSrc=01, Branch_Target=0x40, Flush=1 -> PC=0x40 next cycle; Flush_IF_ID=1 and Flush_ID_EX=1 in the request cycle.
REQ-038 Interrupt: PC=0x33, M[0x01]=0x80, PCSrc=10, inst_mem_src=2 -> Int_Ret_PC=0x33, Int_Save pulses once, PC=0x80 after 2 cycles, and a PCSrc=01 applied mid-load is ignored.
REQ-039 RET and illegal: PCSrc=10, inst_mem_src=3, Ret_Data=0x34 -> PC=0x34 next cycle; PCSrc=11 -> PC holds and Err is a one-cycle pulse.
REQ-040 Reset mid-load: assert Reset during VEC_LOAD of an interrupt -> PC=0x00 immediately, Int_Save=0, and the boot load repeats per REQ-035.
